// File: rtl/block_sync_pkg.sv
// Shared types and header helpers for the block sync seeker and its decoder-side users.
package block_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } seek_state_e;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/block_sync_mux.sv
// Registered barrel extract of a BLOCK_W-bit block from a wider buffer at a runtime offset.
module block_sync_mux #(
    parameter int BUF_W   = 194,
    parameter int BLOCK_W = 66,
    parameter int OFF_W   = 7
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en,
    input  logic [BUF_W-1:0]   buffer,
    input  logic [OFF_W-1:0]   offset,
    output logic [BLOCK_W-1:0] block
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            block <= '0;
        end else if (en) begin
            block <= BLOCK_W'(buffer >> offset);
        end
    end

endmodule

// File: rtl/block_sync_seeker.sv
// Sync-header seeker: hunts for the block offset, qualifies it with lock/unlock hysteresis,
// then forwards aligned blocks. SEEKER_STATS_EN builds the slip / lock-loss counters.
//
// state  | meaning
// SEARCH | testing the current offset, slip on every invalid header
// VERIFY | offset seen valid, counting consecutive valid headers towards LOCK_CNT
// LOCKED | aligned, emitting blocks, counting bad headers per WINDOW samples
module block_sync_seeker
    import block_sync_pkg::*;
#(
    parameter int BUF_W      = 194,
    parameter int BLOCK_W    = 66,
    parameter int NUM_OFF    = BUF_W - BLOCK_W,
    parameter int OFF_W      = $clog2(NUM_OFF),
    parameter int LOCK_CNT   = 32,
    parameter int WINDOW     = 64,
    parameter int UNLOCK_BAD = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [BUF_W-1:0]   gbox_buffer,
    input  logic               buffer_dv,
    input  logic               force_search_i,
    output logic [OFF_W-1:0]   block_offset_o,
    output logic               locked_o,
    output logic               block_dv_o,
    output logic [BLOCK_W-1:0] block_o,
    output logic [1:0]         hdr_o,
    output logic [15:0]        slip_cnt_o,
    output logic [15:0]        lock_loss_cnt_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int BW = $clog2(UNLOCK_BAD + 1);

    generate
        if (LOCK_CNT < 1 || WINDOW < 1 || UNLOCK_BAD < 1 || UNLOCK_BAD > WINDOW) begin : g_param_chk
            $error("block_sync_seeker: illegal LOCK_CNT/WINDOW/UNLOCK_BAD");
        end
    endgenerate

    seek_state_e      state;
    logic [OFF_W-1:0] offset;
    logic [GW-1:0]    good_cnt;
    logic [WW-1:0]    win_cnt;
    logic [BW-1:0]    bad_cnt;
    logic             locked;
    logic             block_dv;

    logic [1:0]       hdr_cur;
    logic             hdr_ok;
    logic [WW-1:0]    win_next;
    logic [BW-1:0]    bad_next;
    logic             win_end;
    logic             unlock_hit;
    logic             sample;
    logic             emit;
    logic             slip_evt;
    logic             loss_evt;
    logic [OFF_W-1:0] next_off;

    assign hdr_cur = 2'(gbox_buffer >> (32'(offset) + 32'(BLOCK_W - 2)));

    always_comb begin
        hdr_ok     = hdr_valid(hdr_cur);
        win_next   = win_cnt + WW'(1);
        bad_next   = bad_cnt + BW'(!hdr_ok);
        win_end    = (win_next == WW'(WINDOW));
        unlock_hit = (bad_next == BW'(UNLOCK_BAD));
        // a forced search discards the coincident sample entirely
        sample     = buffer_dv && !force_search_i;
        emit       = sample && (state == LOCKED);
        slip_evt   = force_search_i ||
                     (sample && (((state != LOCKED) && !hdr_ok) ||
                                 ((state == LOCKED) && unlock_hit)));
        loss_evt   = (state == LOCKED) && (force_search_i || (buffer_dv && unlock_hit));
        next_off   = (offset == OFF_W'(NUM_OFF - 1)) ? '0 : offset + OFF_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= SEARCH;
            offset   <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
            block_dv <= 1'b0;
        end else begin
            block_dv <= emit;
            if (slip_evt) begin
                state    <= SEARCH;
                offset   <= next_off;
                good_cnt <= '0;
                win_cnt  <= '0;
                bad_cnt  <= '0;
                locked   <= 1'b0;
            end else if (buffer_dv) begin
                case (state)
                    SEARCH: begin
                        if (LOCK_CNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state    <= VERIFY;
                            good_cnt <= GW'(1);
                        end
                    end
                    VERIFY: begin
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (win_end) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_next;
                            bad_cnt <= bad_next;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    block_sync_mux #(
        .BUF_W   (BUF_W),
        .BLOCK_W (BLOCK_W),
        .OFF_W   (OFF_W)
    ) u_mux (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en      (emit),
        .buffer  (gbox_buffer),
        .offset  (offset),
        .block   (block_o)
    );

    assign block_offset_o = offset;
    assign locked_o       = locked;
    assign block_dv_o     = block_dv;
    assign hdr_o          = block_o[BLOCK_W-1 -: 2];

`ifdef SEEKER_STATS_EN
    logic [15:0] slip_cnt;
    logic [15:0] loss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slip_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            if (slip_evt && (slip_cnt != 16'hFFFF)) slip_cnt <= slip_cnt + 16'd1;
            if (loss_evt && (loss_cnt != 16'hFFFF)) loss_cnt <= loss_cnt + 16'd1;
        end
    end

    assign slip_cnt_o      = slip_cnt;
    assign lock_loss_cnt_o = loss_cnt;
`else
    logic unused_stats;
    assign unused_stats    = loss_evt;
    assign slip_cnt_o      = 16'h0000;
    assign lock_loss_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_block_sync_seeker.sv
// Directed bench for block_sync_seeker: search, lock, window hysteresis, wrap, force and reset.
module tb_block_sync_seeker;

    localparam int BUF_W   = 194;
    localparam int BLOCK_W = 66;
    localparam int OFF_W   = 7;
`ifdef SEEKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic [BUF_W-1:0]   gbox_buffer = '0;
    logic               buffer_dv = 1'b0;
    logic               force_search_i = 1'b0;
    logic [OFF_W-1:0]   block_offset_o;
    logic               locked_o;
    logic               block_dv_o;
    logic [BLOCK_W-1:0] block_o;
    logic [1:0]         hdr_o;
    logic [15:0]        slip_cnt_o;
    logic [15:0]        lock_loss_cnt_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_slip = '0;
    logic [15:0] exp_loss = '0;
    logic [15:0] exp_s;
    logic [15:0] exp_l;

    logic [BUF_W-1:0]   zero_buf;
    logic [BUF_W-1:0]   b129;
    logic [BUF_W-1:0]   d1;
    logic [BUF_W-1:0]   b0;
    logic [BUF_W-1:0]   b2;
    logic [BLOCK_W-1:0] d1_blk;
    logic [BLOCK_W-1:0] b0_blk;

    block_sync_seeker dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .gbox_buffer     (gbox_buffer),
        .buffer_dv       (buffer_dv),
        .force_search_i  (force_search_i),
        .block_offset_o  (block_offset_o),
        .locked_o        (locked_o),
        .block_dv_o      (block_dv_o),
        .block_o         (block_o),
        .hdr_o           (hdr_o),
        .slip_cnt_o      (slip_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // drive at negedge, observe 1 time unit after the following posedge
    task automatic cycle(input logic dv, input logic [BUF_W-1:0] b, input logic f);
        @(negedge clk_i);
        buffer_dv      = dv;
        gbox_buffer    = b;
        force_search_i = f;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0b expected 0", locked_o); end
        n_vec++; if (block_offset_o !== 7'd0) begin n_err++; $display("FAIL reset_offset: got %0d expected 0", block_offset_o); end
        n_vec++; if (block_dv_o !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %0b expected 0", block_dv_o); end
        n_vec++; if (block_o !== '0) begin n_err++; $display("FAIL reset_block: got %0h expected 0", block_o); end
        n_vec++; if (hdr_o !== 2'b00) begin n_err++; $display("FAIL reset_hdr: got %0b expected 0", hdr_o); end
        n_vec++; if (slip_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_slip: got %0d expected 0", slip_cnt_o); end
        n_vec++; if (lock_loss_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_loss: got %0d expected 0", lock_loss_cnt_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_search_lock();
        int pulses = 0;
        for (int k = 1; k <= 96; k++) begin
            cycle(1'b1, b129, 1'b0);
            pulses += int'(block_dv_o);
            if (k <= 64) exp_slip++;
            if (k == 64) begin
                n_vec++; if (block_offset_o !== 7'd64) begin n_err++; $display("FAIL search_off64: got %0d expected 64", block_offset_o); end
            end
            if (k == 65) begin
                n_vec++; if (block_offset_o !== 7'd64) begin n_err++; $display("FAIL verify_hold_off: got %0d expected 64", block_offset_o); end
            end
            if (k == 95) begin
                n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL early_lock: got %0b expected 0", locked_o); end
            end
            if (k == 96) begin
                n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL lock_rise: got %0b expected 1", locked_o); end
                n_vec++; if (block_offset_o !== 7'd64) begin n_err++; $display("FAIL lock_off: got %0d expected 64", block_offset_o); end
            end
            repeat (7) cycle(1'b0, b129, 1'b0);
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL dv_before_lock: got %0d pulses expected 0", pulses); end
        exp_s = STATS ? exp_slip : 16'h0;
        n_vec++; if (slip_cnt_o !== exp_s) begin n_err++; $display("FAIL search_slips: got %0d expected %0d", slip_cnt_o, exp_s); end
    endtask

    task automatic test_window_hold();
        for (int w = 0; w < 4; w++) begin
            int pulses = 0;
            for (int s = 0; s < 64; s++) begin
                cycle(1'b1, (s < 15) ? zero_buf : d1, 1'b0);
                pulses += int'(block_dv_o);
                if (w == 0 && s == 0) begin
                    n_vec++; if (hdr_o !== 2'b00) begin n_err++; $display("FAIL bad_hdr_forward: got %0b expected 00", hdr_o); end
                end
            end
            n_vec++; if (pulses !== 64) begin n_err++; $display("FAIL window_pulses w%0d: got %0d expected 64", w, pulses); end
        end
        n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL window_hold_lock: got %0b expected 1", locked_o); end
        n_vec++; if (block_offset_o !== 7'd64) begin n_err++; $display("FAIL window_hold_off: got %0d expected 64", block_offset_o); end
    endtask

    task automatic test_unlock();
        cycle(1'b1, d1, 1'b0);
        n_vec++; if (block_dv_o !== 1'b1) begin n_err++; $display("FAIL data_dv: got %0b expected 1", block_dv_o); end
        n_vec++; if (block_o !== d1_blk) begin n_err++; $display("FAIL data_block: got %0h expected %0h", block_o, d1_blk); end
        n_vec++; if (hdr_o !== 2'b10) begin n_err++; $display("FAIL data_hdr: got %0b expected 10", hdr_o); end
        cycle(1'b0, zero_buf, 1'b0);
        n_vec++; if (block_dv_o !== 1'b0) begin n_err++; $display("FAIL dv_pulse_width: got %0b expected 0", block_dv_o); end
        n_vec++; if (block_o !== d1_blk) begin n_err++; $display("FAIL block_hold: got %0h expected %0h", block_o, d1_blk); end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, zero_buf, 1'b0);
            if (i == 14) begin
                n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL unlock_early: got %0b expected 1", locked_o); end
            end
        end
        exp_slip++;
        exp_loss++;
        n_vec++; if (block_dv_o !== 1'b1) begin n_err++; $display("FAIL unlock_sample_dv: got %0b expected 1", block_dv_o); end
        n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL unlock_fall: got %0b expected 0", locked_o); end
        n_vec++; if (block_offset_o !== 7'd65) begin n_err++; $display("FAIL unlock_off: got %0d expected 65", block_offset_o); end
        exp_l = STATS ? exp_loss : 16'h0;
        n_vec++; if (lock_loss_cnt_o !== exp_l) begin n_err++; $display("FAIL unlock_loss_cnt: got %0d expected %0d", lock_loss_cnt_o, exp_l); end
    endtask

    task automatic test_unlock_at_window_end();
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, d1, 1'b0);
            if (i == 30) begin
                n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL relock_early: got %0b expected 0", locked_o); end
            end
        end
        n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL relock65: got %0b expected 1", locked_o); end
        n_vec++; if (block_offset_o !== 7'd65) begin n_err++; $display("FAIL relock65_off: got %0d expected 65", block_offset_o); end
        for (int i = 0; i < 48; i++) cycle(1'b1, d1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, zero_buf, 1'b0);
            if (i == 14) begin
                n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL edge_unlock_early: got %0b expected 1", locked_o); end
            end
        end
        exp_slip++;
        exp_loss++;
        n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL unlock_wins: got %0b expected 0", locked_o); end
        n_vec++; if (block_offset_o !== 7'd66) begin n_err++; $display("FAIL unlock_wins_off: got %0d expected 66", block_offset_o); end
        n_vec++; if (block_dv_o !== 1'b1) begin n_err++; $display("FAIL unlock_wins_dv: got %0b expected 1", block_dv_o); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 61; i++) cycle(1'b1, zero_buf, 1'b0);
        exp_slip += 16'd61;
        n_vec++; if (block_offset_o !== 7'd127) begin n_err++; $display("FAIL off127: got %0d expected 127", block_offset_o); end
        cycle(1'b1, zero_buf, 1'b0);
        exp_slip++;
        n_vec++; if (block_offset_o !== 7'd0) begin n_err++; $display("FAIL wrap_off: got %0d expected 0", block_offset_o); end
        exp_s = STATS ? exp_slip : 16'h0;
        n_vec++; if (slip_cnt_o !== exp_s) begin n_err++; $display("FAIL wrap_slip_cnt: got %0d expected %0d", slip_cnt_o, exp_s); end
    endtask

    task automatic test_force();
        for (int i = 0; i < 32; i++) cycle(1'b1, b0, 1'b0);
        n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL lock0: got %0b expected 1", locked_o); end
        cycle(1'b1, b0, 1'b0);
        n_vec++; if (block_o !== b0_blk) begin n_err++; $display("FAIL block_off0: got %0h expected %0h", block_o, b0_blk); end
        n_vec++; if (hdr_o !== 2'b01) begin n_err++; $display("FAIL hdr_off0: got %0b expected 01", hdr_o); end
        cycle(1'b1, b0, 1'b1);
        exp_slip++;
        exp_loss++;
        n_vec++; if (block_dv_o !== 1'b0) begin n_err++; $display("FAIL force_dv: got %0b expected 0", block_dv_o); end
        n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL force_unlock: got %0b expected 0", locked_o); end
        n_vec++; if (block_offset_o !== 7'd1) begin n_err++; $display("FAIL force_off: got %0d expected 1", block_offset_o); end
        exp_l = STATS ? exp_loss : 16'h0;
        n_vec++; if (lock_loss_cnt_o !== exp_l) begin n_err++; $display("FAIL force_loss_cnt: got %0d expected %0d", lock_loss_cnt_o, exp_l); end
        cycle(1'b0, b0, 1'b1);
        exp_slip++;
        n_vec++; if (block_offset_o !== 7'd2) begin n_err++; $display("FAIL force_idle_off: got %0d expected 2", block_offset_o); end
        exp_l = STATS ? exp_loss : 16'h0;
        n_vec++; if (lock_loss_cnt_o !== exp_l) begin n_err++; $display("FAIL force_idle_loss: got %0d expected %0d", lock_loss_cnt_o, exp_l); end
        exp_s = STATS ? exp_slip : 16'h0;
        n_vec++; if (slip_cnt_o !== exp_s) begin n_err++; $display("FAIL force_slip_cnt: got %0d expected %0d", slip_cnt_o, exp_s); end
    endtask

    task automatic test_reset_mid_verify();
        for (int i = 0; i < 20; i++) cycle(1'b1, b2, 1'b0);
        n_vec++; if (block_offset_o !== 7'd2) begin n_err++; $display("FAIL verify_off2: got %0d expected 2", block_offset_o); end
        @(negedge clk_i);
        buffer_dv = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        exp_slip = '0;
        exp_loss = '0;
        n_vec++; if (block_offset_o !== 7'd0) begin n_err++; $display("FAIL arst_off: got %0d expected 0", block_offset_o); end
        n_vec++; if (block_o !== '0) begin n_err++; $display("FAIL arst_block: got %0h expected 0", block_o); end
        n_vec++; if (slip_cnt_o !== 16'h0) begin n_err++; $display("FAIL arst_slip: got %0d expected 0", slip_cnt_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b1, b2, 1'b0);
        exp_slip++;
        n_vec++; if (block_offset_o !== 7'd1) begin n_err++; $display("FAIL restart_off1: got %0d expected 1", block_offset_o); end
        cycle(1'b1, b2, 1'b0);
        exp_slip++;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, b2, 1'b0);
            if (i == 30) begin
                n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL restart_early_lock: got %0b expected 0", locked_o); end
            end
        end
        n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL restart_lock: got %0b expected 1", locked_o); end
        n_vec++; if (block_offset_o !== 7'd2) begin n_err++; $display("FAIL restart_lock_off: got %0d expected 2", block_offset_o); end
        exp_s = STATS ? exp_slip : 16'h0;
        n_vec++; if (slip_cnt_o !== exp_s) begin n_err++; $display("FAIL restart_slip_cnt: got %0d expected %0d", slip_cnt_o, exp_s); end
    endtask

    initial begin
        zero_buf = '0;
        b129 = '0;
        b129[129] = 1'b1;
        d1 = b129;
        d1[127:64] = 64'hDEAD_BEEF_0123_4567;
        d1_blk = {2'b10, 64'hDEAD_BEEF_0123_4567};
        b0 = '0;
        b0[64] = 1'b1;
        b0[63:0] = 64'h0123_4567_89AB_CDEF;
        b0_blk = {2'b01, 64'h0123_4567_89AB_CDEF};
        b2 = '0;
        b2[67] = 1'b1;

        test_reset();
        test_search_lock();
        test_window_hold();
        test_unlock();
        test_unlock_at_window_end();
        test_wrap();
        test_force();
        test_reset_mid_verify();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
